weight_fifo_mac: RTL
====================

WEIGHT_FIFO_MAC -- requirements
Module: weight_fifo_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: FIFO word width, 16 signed int8 weights.
REQ-002 SHALL have parameter NUM_INPUTS, default 784: pixels per neuron, a multiple of 16.
REQ-003 SHALL have parameter NUM_NEURONS, default 256: neurons per layer pass.
REQ-004 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-005 SHALL have port clk  in  1: single clock for all logic.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have port start  in  1: one-cycle pulse that begins a layer pass.
REQ-008 SHALL have port fifo_empty  in  1: weight FIFO is empty.
REQ-009 SHALL have port fifo_rdata  in  DATA_WIDTH: FIFO read data, valid the cycle after fifo_rdreq.
REQ-010 SHALL have port fifo_rdreq  out  1: FIFO read request.
REQ-011 SHALL have port img_addr  out  10: image RAM byte address.
REQ-012 SHALL have port img_data  in  8: unsigned pixel, valid the cycle after img_addr.
REQ-013 SHALL have port result_valid  out  1: one-cycle neuron-result strobe.
REQ-014 SHALL have port result_index  out  8: neuron number of the current result.
REQ-015 SHALL have port result_acc  out  ACC_WIDTH: signed dot product.
REQ-016 SHALL have port busy  out  1: high in any state except IDLE.
REQ-017 SHALL have port mac_done  out  1: one-cycle pulse at the end of a pass.

Function
REQ-018 SHALL implement the FSM IDLE -> FETCH -> LOAD -> MAC -> (FETCH | DONE) -> IDLE.
REQ-019 SHALL move from IDLE to FETCH when start=1; start SHALL be ignored in all other states.
REQ-020 SHALL, in FETCH, drive fifo_rdreq=1 combinationally only when fifo_empty=0 and go to LOAD; otherwise it SHALL hold in FETCH with no state change.
REQ-021 SHALL assert fifo_rdreq only in FETCH and at most once per word.
REQ-022 SHALL, in LOAD, register fifo_rdata into a word register and drive img_addr for lane 0.
REQ-023 SHALL spend exactly 16 cycles in MAC; on cycle j it SHALL accumulate lane j and drive img_addr for lane j+1 (j<15).
REQ-024 SHALL take lane j as word bits [8j+7:8j] and pair it with pixel address word_idx*16+j, where word_idx = 0..NUM_INPUTS/16-1 (0..48).
REQ-025 SHALL compute each product as signed weight x zero-extended pixel, sign-extend it to ACC_WIDTH, and add it with two's-complement wrap and no saturation.
REQ-026 SHALL, after the last MAC cycle of a non-final word, return to FETCH with word_idx+1.
REQ-027 SHALL, after the last MAC cycle of the final word (word_idx=48), do all of the following on the next cycle:
  - assert result_valid=1;
  - present result_acc = full sum including lane 15;
  - present result_index = neuron count;
  - clear the accumulator and word_idx;
  - advance the neuron count.
REQ-028 SHALL go to FETCH after that final word if neurons remain, or to DONE otherwise.
REQ-029 SHALL drive mac_done=1 for the single DONE cycle, coincident with the last result_valid, then return to IDLE.
REQ-030 SHALL hold result_acc and result_index until the next result, with result_valid low between strobes.
REQ-031 SHALL take 18 cycles per word with no FIFO stall; each stall cycle adds exactly one cycle.
REQ-032 SHALL assert mac_done 1+NUM_NEURONS*(NUM_INPUTS/16)*18 cycles after the start cycle with no stalls (225793 at defaults).
REQ-033 SHALL wrap the neuron count to 0 after NUM_NEURONS-1; no other counter SHALL wrap.

Reset
REQ-034 SHALL, while reset=1, force the state to IDLE and clear the accumulator, word_idx, neuron count and word register.
REQ-035 SHALL, while reset=1, drive fifo_rdreq, img_addr, result_valid, result_index, result_acc, busy and mac_done to 0.
REQ-036 SHALL let reset win over start in the same cycle, and a reset mid-pass SHALL abandon the pass with no result or done strobe.

Verification
REQ-037 SHALL cover: all weights 0x01, all pixels 1, FIFO never empty -> 256 results of 784 with indices 0..255, mac_done at cycle 225793.
REQ-038 SHALL cover: all weights 0xFF, all pixels 255 -> every result_acc = 0xFFFCF310 (-199920).
REQ-039 SHALL cover: neuron 0 word 0 with only byte 5=0x02, pixel[5]=10, all else 0 -> result_index 0, result_acc 20.
REQ-040 SHALL cover: fifo_empty held high 10 cycles in FETCH of neuron 2 -> fifo_rdreq low throughout, results unchanged, mac_done 10 cycles later.
REQ-041 SHALL cover: reset pulse during neuron 3, then start -> outputs 0 the cycle after reset, first new result has index 0 and the correct value.
REQ-042 SHALL cover: start pulses while busy -> no restart, result sequence and mac_done timing unchanged.

Source files
------------

// File: rtl/weight_fifo_mac_if.sv
// ---------------------------------------------------------------------------
// weight_fifo_mac_if
//   Bus bundle between the weight-FIFO MAC engine and its environment.
//
//   fifo_empty   : weight FIFO is empty                        (env -> MAC)
//   fifo_rdata   : FIFO read data, valid the cycle after rdreq (env -> MAC)
//   fifo_rdreq   : FIFO read request                           (MAC -> env)
//   img_addr     : image RAM byte address                      (MAC -> env)
//   img_data     : unsigned pixel, valid the cycle after addr  (env -> MAC)
//   result_valid : one-cycle neuron-result strobe              (MAC -> env)
//   result_index : neuron number of the current result         (MAC -> env)
//   result_acc   : signed dot product                          (MAC -> env)
//
//   master = MAC engine side, slave = FIFO / image RAM / result consumer.
// ---------------------------------------------------------------------------
interface weight_fifo_mac_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ACC_WIDTH  = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_rdreq;
    logic [9:0]            img_addr;
    logic [7:0]            img_data;
    logic                  result_valid;
    logic [7:0]            result_index;
    logic [ACC_WIDTH-1:0]  result_acc;

    modport master (
        input  fifo_empty, fifo_rdata, img_data,
        output fifo_rdreq, img_addr, result_valid, result_index, result_acc
    );

    modport slave (
        output fifo_empty, fifo_rdata, img_data,
        input  fifo_rdreq, img_addr, result_valid, result_index, result_acc
    );
endinterface

// File: rtl/weight_fifo_mac.sv
// ---------------------------------------------------------------------------
// weight_fifo_mac
//   Streams 128-bit weight words (16 signed int8 lanes) from a FIFO and
//   multiplies them against unsigned 8-bit pixels read from an image RAM,
//   producing one signed dot product per neuron. A pass covers NUM_NEURONS
//   neurons of NUM_INPUTS pixels each; every word costs 18 cycles
//   (FETCH + LOAD + 16 MAC) plus one cycle per FIFO-empty stall.
//
//   clk      : single clock
//   reset    : synchronous, active-high
//   start    : one-cycle pulse, begins a pass (ignored unless idle)
//   busy     : high in any state except IDLE
//   mac_done : one-cycle pulse in the DONE state, with the last result
//   bus      : FIFO, image RAM and result signals (weight_fifo_mac_if.master)
// ---------------------------------------------------------------------------
module weight_fifo_mac #(
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 256,
    parameter int ACC_WIDTH   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              mac_done,
    weight_fifo_mac_if.master bus
);
    localparam int NUM_WORDS = NUM_INPUTS / 16;
    localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PROD_W    = 17;   // int8 x zero-extended uint8

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_MAC,
        S_DONE
    } state_t;

    state_t                       state_q;
    logic [DATA_WIDTH-1:0]        word_q;
    logic [WIDX_W-1:0]            word_idx_q;
    logic [3:0]                   lane_q;
    logic [7:0]                   neuron_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         result_valid_q;
    logic [7:0]                   result_index_q;
    logic [ACC_WIDTH-1:0]         result_acc_q;
    logic                         mac_done_q;

    logic signed [7:0]            weight;
    logic signed [8:0]            pixel;
    logic signed [PROD_W-1:0]     product;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic [3:0]                   next_lane;
    logic [9:0]                   addr_base;
    logic                         last_lane;
    logic                         last_word;
    logic                         last_neuron;

    // Datapath: one lane per MAC cycle. The pixel arriving now was
    // addressed in the previous cycle, which is lane_q by construction.
    always_comb begin
        // NOTE: every combinational output gets a default on entry so no
        // path through the block leaves it unassigned and infers a latch.
        weight      = word_q[{lane_q, 3'b000} +: 8];
        pixel       = {1'b0, bus.img_data};
        product     = weight * pixel;
        acc_d       = acc_q + {{(ACC_WIDTH-PROD_W){product[PROD_W-1]}}, product};
        next_lane   = lane_q + 4'd1;
        addr_base   = 10'({word_idx_q, 4'b0000});
        last_lane   = (lane_q == 4'd15);
        last_word   = (word_idx_q == WIDX_W'(NUM_WORDS - 1));
        last_neuron = (neuron_q == 8'(NUM_NEURONS - 1));
    end

    // Outputs. Reset is synchronous, so the registered outputs are also
    // gated here to read zero during the very first reset cycle.
    always_comb begin
        bus.fifo_rdreq   = 1'b0;
        bus.img_addr     = '0;
        bus.result_valid = 1'b0;
        bus.result_index = '0;
        bus.result_acc   = '0;
        busy             = 1'b0;
        mac_done         = 1'b0;
        if (!reset) begin
            // Read strobe is combinational so a non-empty FIFO costs no
            // extra cycle; FETCH lasts one cycle per word, hence one read.
            bus.fifo_rdreq   = (state_q == S_FETCH) && !bus.fifo_empty;
            bus.result_valid = result_valid_q;
            bus.result_index = result_index_q;
            bus.result_acc   = result_acc_q;
            busy             = (state_q != S_IDLE);
            mac_done         = mac_done_q;
            if (state_q == S_LOAD) begin
                bus.img_addr = addr_base;
            end else if (state_q == S_MAC && !last_lane) begin
                bus.img_addr = addr_base + 10'(next_lane);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: word_q is a single register rather than a memory array,
            // so it is cleared here along with the other state.
            state_q        <= S_IDLE;
            word_q         <= '0;
            word_idx_q     <= '0;
            lane_q         <= '0;
            neuron_q       <= '0;
            acc_q          <= '0;
            result_valid_q <= 1'b0;
            result_index_q <= '0;
            result_acc_q   <= '0;
            mac_done_q     <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            mac_done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!bus.fifo_empty) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    word_q  <= bus.fifo_rdata;
                    lane_q  <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    lane_q <= next_lane;
                    if (!last_lane) begin
                        acc_q <= acc_d;
                    end else if (!last_word) begin
                        acc_q      <= acc_d;
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= S_FETCH;
                    end else begin
                        // Neuron complete: publish the full sum (lane 15
                        // included) and start the next neuron from zero.
                        result_valid_q <= 1'b1;
                        result_acc_q   <= acc_d;
                        result_index_q <= neuron_q;
                        acc_q          <= '0;
                        word_idx_q     <= '0;
                        neuron_q       <= last_neuron ? 8'd0 : neuron_q + 8'd1;
                        mac_done_q     <= last_neuron;
                        state_q        <= last_neuron ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
